// File: rtl/aes_round_sched.sv
// AES round scheduler: steps one 128-bit block through NROUNDS calls of an external
// round core, with a per-round watchdog and a valid/ready output handshake.
//
// state | meaning
// IDLE  | waiting for a block, in_ready high
// RUN   | core_enable high, operands held until core_done
// GAP   | single idle cycle between rounds
// OUT   | ciphertext offered on out_text until out_ready
// ERR   | core timed out; held until err_clear

module aes_round_sched #(
    parameter int NROUNDS = 10,
    parameter int TIMEOUT = 255
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_text,
    input  logic [127:0] in_key,
    output logic         core_enable,
    output logic [127:0] core_i_text,
    output logic [127:0] core_key,
    output logic [3:0]   core_round,
    input  logic [127:0] core_o_text,
    input  logic [127:0] core_Rkey,
    input  logic         core_done,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_text,
    output logic         busy,
    output logic         error,
    input  logic         err_clear,
    output logic [15:0]  block_count
);

    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [TW-1:0] TMR_LOAD   = TW'(TIMEOUT - 1);
    localparam logic [3:0]    LAST_ROUND = 4'(NROUNDS - 1);

    typedef enum logic [2:0] {IDLE, RUN, GAP, OUT, ERR} fsm_t;

    fsm_t           fsm;
    logic [127:0]   blk_state;
    logic [127:0]   key_reg;
    logic [3:0]     round;
    logic [TW-1:0]  timer;
    logic [15:0]    blk_cnt;

    // Watchdog counts down from TIMEOUT-1; terminal count in RUN without core_done
    // means the round has used up its TIMEOUT cycles.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fsm       <= IDLE;
            blk_state <= '0;
            key_reg   <= '0;
            round     <= '0;
            timer     <= '0;
            blk_cnt   <= '0;
        end else begin
            case (fsm)
                IDLE: begin
                    if (in_valid) begin
                        blk_state <= in_text ^ in_key;
                        key_reg   <= in_key;
                        round     <= '0;
                        timer     <= TMR_LOAD;
                        fsm       <= RUN;
                    end
                end
                RUN: begin
                    if (core_done) begin
                        blk_state <= core_o_text;
                        key_reg   <= core_Rkey;
                        if (round == LAST_ROUND) begin
                            fsm <= OUT;
                        end else begin
                            round <= round + 4'd1;
                            fsm   <= GAP;
                        end
                    end else if (timer == '0) begin
                        fsm <= ERR;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                GAP: begin
                    timer <= TMR_LOAD;
                    fsm   <= RUN;
                end
                OUT: begin
                    if (out_ready) begin
                        blk_cnt <= blk_cnt + 16'd1;
                        fsm     <= IDLE;
                    end
                end
                ERR: begin
                    if (err_clear) fsm <= IDLE;
                end
                default: fsm <= IDLE;
            endcase
        end
    end

    // in_ready is also gated by reset so it stays low for the whole reset pulse.
    assign in_ready    = (fsm == IDLE) && !reset;
    assign core_enable = (fsm == RUN);
    assign core_i_text = blk_state;
    assign core_key    = key_reg;
    assign core_round  = round;
    assign out_valid   = (fsm == OUT);
    assign out_text    = blk_state;
    assign busy        = (fsm == RUN) || (fsm == GAP);
    assign error       = (fsm == ERR);
    assign block_count = blk_cnt;

endmodule

// File: tb/tb_aes_round_sched.sv
// Directed bench for aes_round_sched: a behavioural AES-128 round core with
// programmable response delay, checked against FIPS-197 known-answer vectors.
module tb_aes_round_sched;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] in_text = '0;
    logic [127:0] in_key = '0;
    logic         core_enable;
    logic [127:0] core_i_text, core_key, core_o_text, core_Rkey;
    logic [3:0]   core_round;
    logic         core_done;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] out_text;
    logic         busy, error;
    logic         err_clear = 1'b0;
    logic [15:0]  block_count;

    int tests = 0;
    int fails = 0;

    localparam logic [127:0] PT1    = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY1   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT1    = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] ARK1   = 128'h00102030405060708090a0b0c0d0e0f0;
    localparam logic [127:0] R1_OUT = 128'h89d810e8855ace682d1843d8cb128fe4;
    localparam logic [127:0] R1_KEY = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
    localparam logic [127:0] PT2    = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] KEY2   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT2    = 128'h3925841d02dc09fbdc118597196a0b32;

    aes_round_sched #(.NROUNDS(10), .TIMEOUT(255)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_text(in_text), .in_key(in_key),
        .core_enable(core_enable), .core_i_text(core_i_text), .core_key(core_key),
        .core_round(core_round), .core_o_text(core_o_text), .core_Rkey(core_Rkey),
        .core_done(core_done),
        .out_valid(out_valid), .out_ready(out_ready), .out_text(out_text),
        .busy(busy), .error(error), .err_clear(err_clear), .block_count(block_count)
    );

    always #5 clock = ~clock;

    // ---------------- behavioural AES-128 round core ----------------
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r, aa;
        r = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r = r ^ aa;
            aa = xt(aa);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] inv, p, e;
        inv = 8'h01;
        p = x;
        e = 8'd254;
        for (int i = 0; i < 8; i++) begin
            if (e[i]) inv = gmul(inv, p);
            p = gmul(p, p);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                   ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] key_exp(input logic [127:0] k, input logic [3:0] rnd);
        logic [31:0] w0, w1, w2, w3, t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < int'(rnd); i++) rc = xt(rc);
        w0 = k[127:96]; w1 = k[95:64]; w2 = k[63:32]; w3 = k[31:0];
        t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rc, 24'h0};
        w0 = w0 ^ t; w1 = w1 ^ w0; w2 = w2 ^ w1; w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] rk,
                                               input logic last);
        logic [7:0]   b [16];
        logic [7:0]   sh[16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] o;
        for (int i = 0; i < 16; i++) b[i] = sbox(s[127 - 8*i -: 8]);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) sh[r + 4*c] = b[r + 4*((c + r) % 4)];
        for (int c = 0; c < 4; c++) begin
            a0 = sh[4*c]; a1 = sh[4*c+1]; a2 = sh[4*c+2]; a3 = sh[4*c+3];
            if (!last) begin
                sh[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                sh[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                sh[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                sh[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
            end
        end
        for (int i = 0; i < 16; i++) o[127 - 8*i -: 8] = sh[i];
        return o ^ rk;
    endfunction

    // core_done rises once core_enable has been high for core_wait full cycles;
    // slow_round selects one round that uses slow_wait instead.
    int core_wait  = 2;
    int slow_round = -1;
    int slow_wait  = 0;
    bit force_done = 1'b0;
    int run_cnt    = 0;

    always @(posedge clock) run_cnt <= core_enable ? run_cnt + 1 : 0;

    assign core_done = force_done ||
        (core_enable && (run_cnt >= ((int'(core_round) == slow_round) ? slow_wait : core_wait)));
    assign core_Rkey   = key_exp(core_key, core_round);
    assign core_o_text = aes_round(core_i_text, core_Rkey, core_round == 4'd9);

    // ---------------- stimulus helpers ----------------
    task automatic send_block(input logic [127:0] t, input logic [127:0] k);
        @(negedge clock);
        in_text  = t;
        in_key   = k;
        in_valid = 1'b1;
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    // cyc counts cycles from the handshake cycle to the first out_valid cycle; -1 on expiry.
    task automatic wait_out(input int start, input int budget, output int cyc);
        cyc = start;
        while (out_valid !== 1'b1 && cyc < budget) begin
            @(negedge clock);
            cyc++;
        end
        if (out_valid !== 1'b1) cyc = -1;
    endtask

    task automatic take_out();
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
        tests++; if ({core_enable, out_valid, busy, error} !== 4'b0000) begin
            fails++; $display("FAIL rst_flags: got %b want 0000", {core_enable, out_valid, busy, error}); end
        tests++; if (block_count !== 16'h0000) begin fails++; $display("FAIL rst_count: got %h want 0000", block_count); end
        tests++; if (out_text !== 128'h0 || core_key !== 128'h0) begin
            fails++; $display("FAIL rst_data: got %h/%h want 0", out_text, core_key); end
        reset = 1'b0;
        #1;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rst_release_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_basic();
        int lat;
        core_wait = 2; slow_round = -1;
        send_block(PT1, KEY1);
        tests++; if ({core_enable, busy, in_ready} !== 3'b110 || core_round !== 4'd0) begin
            fails++; $display("FAIL run0_ctrl: got en/busy/rdy %b round %0d want 110 round 0",
                              {core_enable, busy, in_ready}, core_round); end
        tests++; if (core_i_text !== ARK1 || core_key !== KEY1) begin
            fails++; $display("FAIL run0_operands: got %h/%h want %h/%h", core_i_text, core_key, ARK1, KEY1); end
        repeat (3) @(negedge clock);
        tests++; if ({core_enable, busy} !== 2'b01 || core_round !== 4'd1) begin
            fails++; $display("FAIL gap_ctrl: got en/busy %b round %0d want 01 round 1", {core_enable, busy}, core_round); end
        tests++; if (core_i_text !== R1_OUT || core_key !== R1_KEY) begin
            fails++; $display("FAIL gap_operands: got %h/%h want %h/%h", core_i_text, core_key, R1_OUT, R1_KEY); end
        wait_out(4, 400, lat);
        tests++; if (lat !== 40) begin fails++; $display("FAIL basic_latency: got %0d want 40", lat); end
        tests++; if (out_text !== CT1) begin fails++; $display("FAIL basic_text: got %h want %h", out_text, CT1); end
        tests++; if ({busy, in_ready, error} !== 3'b000) begin
            fails++; $display("FAIL out_flags: got %b want 000", {busy, in_ready, error}); end
        take_out();
        tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || block_count !== 16'd1) begin
            fails++; $display("FAIL basic_handshake: got v%b r%b cnt %0d want v0 r1 cnt 1", out_valid, in_ready, block_count); end
    endtask

    task automatic test_backpressure();
        int lat;
        int hold_bad = 0;
        send_block(PT1, KEY1);
        wait_out(1, 400, lat);
        tests++; if (lat !== 40) begin fails++; $display("FAIL bp_latency: got %0d want 40", lat); end
        in_text = PT2; in_key = KEY2; in_valid = 1'b1; force_done = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (out_valid !== 1'b1 || out_text !== CT1 || in_ready !== 1'b0) hold_bad++;
        end
        tests++; if (hold_bad !== 0) begin fails++; $display("FAIL bp_hold: got %0d bad cycles want 0", hold_bad); end
        take_out();
        tests++; if ({out_valid, busy, in_ready} !== 3'b001 || block_count !== 16'd2) begin
            fails++; $display("FAIL bp_release: got v/b/r %b cnt %0d want 001 cnt 2", {out_valid, busy, in_ready}, block_count); end
        in_valid = 1'b0;
        @(negedge clock);
        tests++; if ({busy, in_ready} !== 2'b01) begin
            fails++; $display("FAIL idle_done_ignored: got busy/rdy %b want 01", {busy, in_ready}); end
        force_done = 1'b0;
    endtask

    task automatic test_timeout_exact();
        int lat;
        slow_round = 4; slow_wait = 254;
        send_block(PT2, KEY2);
        wait_out(1, 800, lat);
        tests++; if (lat !== 292) begin fails++; $display("FAIL edge_latency: got %0d want 292", lat); end
        tests++; if (out_text !== CT2 || error !== 1'b0) begin
            fails++; $display("FAIL edge_result: got %h err %b want %h err 0", out_text, error, CT2); end
        take_out();
        tests++; if (block_count !== 16'd3) begin fails++; $display("FAIL edge_count: got %0d want 3", block_count); end
        slow_round = -1;
    endtask

    task automatic test_timeout();
        int n = 0;
        slow_round = 4; slow_wait = 1000000;
        send_block(PT1, KEY1);
        for (int i = 0; i < 1000; i++) begin
            @(negedge clock);
            if (error === 1'b1) break;
            if (core_enable === 1'b1 && core_round === 4'd4) n++;
        end
        tests++; if (error !== 1'b1 || n !== 255) begin
            fails++; $display("FAIL to_cycles: got err %b after %0d run cycles want err 1 after 255", error, n); end
        tests++; if ({core_enable, in_ready, out_valid, busy} !== 4'b0000) begin
            fails++; $display("FAIL to_outputs: got %b want 0000", {core_enable, in_ready, out_valid, busy}); end
        in_text = PT2; in_key = KEY2; in_valid = 1'b1;
        repeat (5) @(negedge clock);
        in_valid = 1'b0;
        tests++; if (error !== 1'b1 || in_ready !== 1'b0) begin
            fails++; $display("FAIL to_sticky: got err %b rdy %b want 1 0", error, in_ready); end
        err_clear = 1'b1;
        @(negedge clock);
        err_clear = 1'b0;
        tests++; if ({error, in_ready, busy} !== 3'b010 || block_count !== 16'd3) begin
            fails++; $display("FAIL to_clear: got err/rdy/busy %b cnt %0d want 010 cnt 3", {error, in_ready, busy}, block_count); end
        slow_round = -1;
    endtask

    task automatic test_clear_ignored();
        int lat;
        send_block(PT2, KEY2);
        err_clear = 1'b1;
        repeat (2) @(negedge clock);
        err_clear = 1'b0;
        wait_out(3, 400, lat);
        tests++; if (lat !== 40 || out_text !== CT2 || error !== 1'b0) begin
            fails++; $display("FAIL clr_ignored: got lat %0d %h err %b want 40 %h 0", lat, out_text, error, CT2); end
        take_out();
        tests++; if (block_count !== 16'd4) begin fails++; $display("FAIL clr_count: got %0d want 4", block_count); end
    endtask

    task automatic test_reset_mid();
        int lat;
        int seen = 0;
        int bad = 0;
        send_block(PT1, KEY1);
        for (int i = 0; i < 100 && seen == 0; i++) begin
            @(negedge clock);
            if (core_enable === 1'b1 && core_round === 4'd6) seen = 1;
        end
        tests++; if (seen !== 1) begin fails++; $display("FAIL mid_reach6: got %0d want 1", seen); end
        reset = 1'b1;
        #1;
        tests++; if ({in_ready, core_enable, out_valid, busy, error} !== 5'b0 || core_round !== 4'd0 ||
                     block_count !== 16'd0) begin
            fails++; $display("FAIL mid_async: got %b round %0d cnt %0d want 0", {in_ready, core_enable, out_valid, busy, error},
                              core_round, block_count); end
        @(negedge clock);
        reset = 1'b0;
        #1;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL mid_release: got %b want 1", in_ready); end
        repeat (60) begin
            @(negedge clock);
            if (out_valid !== 1'b0 || busy !== 1'b0) bad++;
        end
        tests++; if (bad !== 0) begin fails++; $display("FAIL mid_discard: got %0d bad cycles want 0", bad); end
        send_block(PT2, KEY2);
        wait_out(1, 400, lat);
        tests++; if (lat !== 40 || out_text !== CT2) begin
            fails++; $display("FAIL mid_next: got lat %0d %h want 40 %h", lat, out_text, CT2); end
        take_out();
        tests++; if (block_count !== 16'd1) begin fails++; $display("FAIL mid_count: got %0d want 1", block_count); end
    endtask

    task automatic test_wrap();
        int lat;
        core_wait = 0;
        force dut.blk_cnt = 16'hfffe;
        @(negedge clock);
        release dut.blk_cnt;
        send_block(PT1, KEY1);
        wait_out(1, 200, lat);
        tests++; if (lat !== 20 || out_text !== CT1) begin
            fails++; $display("FAIL fast_block: got lat %0d %h want 20 %h", lat, out_text, CT1); end
        take_out();
        tests++; if (block_count !== 16'hffff) begin fails++; $display("FAIL wrap_ffff: got %h want ffff", block_count); end
        send_block(PT2, KEY2);
        wait_out(1, 200, lat);
        tests++; if (lat !== 20 || out_text !== CT2) begin
            fails++; $display("FAIL wrap_block: got lat %0d %h want 20 %h", lat, out_text, CT2); end
        take_out();
        tests++; if (block_count !== 16'h0000) begin fails++; $display("FAIL wrap_zero: got %h want 0000", block_count); end
        tests++; if ({out_valid, error, busy, in_ready} !== 4'b0001) begin
            fails++; $display("FAIL wrap_side: got %b want 0001", {out_valid, error, busy, in_ready}); end
        core_wait = 2;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_timeout_exact();
        test_timeout();
        test_clear_ignored();
        test_reset_mid();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got no completion");
        $fatal(1, "watchdog expired");
    end

endmodule
